// File: rtl/mem_controller.sv
// Byte-wide RAM/IO bus sequencer arbitrating between instruction fetch and the load/store buffer.
// Multi-byte accesses are serialised into one byte per cycle; reads return one cycle late.
module mem_controller #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [1:0]  IO_ADDR_HI = 2'b11
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst_n,
  input  logic                  Sys_rdy,
  input  logic                  RoB_clear,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  IFMC_en,
  input  logic [ADDR_WIDTH-1:0] IFMC_addr,
  output logic                  MCIF_en,
  output logic [31:0]           MCIF_data,
  input  logic                  LSBMC_en,
  input  logic                  LSBMC_wr,
  input  logic [1:0]            LSBMC_data_width,
  input  logic [31:0]           LSBMC_data,
  input  logic [ADDR_WIDTH-1:0] LSBMC_addr,
  output logic                  MCLSB_ready,
  output logic                  MCLSB_en,
  output logic [7:0]            MCLSB_data,
  output logic [1:0]            MCLSB_data_number,
  output logic                  MCLSB_wr_done
);

  typedef enum logic [1:0] {StIdle, StIfRead, StLsbRead, StLsbWrite} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            op_last_q, op_last_d;
  logic                  last_grant_lsb_q, last_grant_lsb_d;
  logic                  lsb_pending_q, lsb_pending_d;
  logic                  lsb_rd_q, lsb_rd_d;
  logic [1:0]            lsb_last_q, lsb_last_d;
  logic [31:0]           lsb_data_q, lsb_data_d;
  logic [ADDR_WIDTH-1:0] lsb_addr_q, lsb_addr_d;
  logic [23:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  mcif_en_q, mcif_en_d;
  logic [31:0]           mcif_data_q, mcif_data_d;
  logic                  mclsb_en_q, mclsb_en_d;
  logic [7:0]            mclsb_data_q, mclsb_data_d;
  logic [1:0]            mclsb_num_q, mclsb_num_d;
  logic                  wr_done_q, wr_done_d;

  logic                  mclsb_ready;
  logic                  lsb_take;
  logic                  if_req;
  logic                  grant_lsb;
  logic                  grant_if;
  logic                  io_stall;
  logic [2:0]            cnt_inc;
  logic [2:0]            last_p1;
  logic [1:0]            cap_idx;
  logic [1:0]            byte_sel;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Width code 1 -> 1 byte, 2 -> 2 bytes, anything else -> 4 bytes; stored as last byte index.
  function automatic logic [1:0] width_to_last(input logic [1:0] w);
    unique case (w)
      2'd1:    return 2'd0;
      2'd2:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  assign mclsb_ready = !lsb_pending_q && (state_q != StLsbRead) && (state_q != StLsbWrite);
  assign lsb_take    = LSBMC_en && mclsb_ready;
  // The fetch request is still high in the cycle MCIF_en pulses; don't refetch it.
  assign if_req      = IFMC_en && !mcif_en_q;
  assign grant_lsb   = lsb_pending_q && (!if_req || !last_grant_lsb_q);
  assign grant_if    = if_req && !grant_lsb;
  assign io_stall    = (mem_a_q[17:16] == IO_ADDR_HI) && io_buffer_full;
  assign cnt_inc     = cnt_q + 3'd1;
  assign last_p1     = {1'b0, op_last_q} + 3'd1;
  assign cap_idx     = cnt_q[1:0] - 2'd1;
  assign byte_sel    = cnt_inc[1:0];
  assign next_addr   = addr_q + ADDR_WIDTH'(cnt_inc);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    addr_d           = addr_q;
    op_last_d        = op_last_q;
    last_grant_lsb_d = last_grant_lsb_q;
    lsb_pending_d    = lsb_pending_q;
    lsb_rd_d         = lsb_rd_q;
    lsb_last_d       = lsb_last_q;
    lsb_data_d       = lsb_data_q;
    lsb_addr_d       = lsb_addr_q;
    word_d           = word_q;
    mem_a_d          = mem_a_q;
    mem_dout_d       = mem_dout_q;
    mem_wr_d         = mem_wr_q;
    mcif_en_d        = 1'b0;
    mcif_data_d      = mcif_data_q;
    mclsb_en_d       = 1'b0;
    mclsb_data_d     = mclsb_data_q;
    mclsb_num_d      = mclsb_num_q;
    wr_done_d        = 1'b0;

    if (lsb_take) begin
      lsb_pending_d = 1'b1;
      lsb_rd_d      = LSBMC_wr;
      lsb_last_d    = width_to_last(LSBMC_data_width);
      lsb_data_d    = LSBMC_data;
      lsb_addr_d    = LSBMC_addr;
    end

    unique case (state_q)
      StIdle: begin
        if (!RoB_clear) begin
          if (grant_lsb) begin
            state_d          = lsb_rd_q ? StLsbRead : StLsbWrite;
            lsb_pending_d    = 1'b0;
            last_grant_lsb_d = 1'b1;
            addr_d           = lsb_addr_q;
            op_last_d        = lsb_last_q;
            cnt_d            = 3'd0;
            mem_a_d          = lsb_addr_q;
            mem_wr_d         = !lsb_rd_q;
            mem_dout_d       = lsb_data_q[7:0];
          end else if (grant_if) begin
            state_d          = StIfRead;
            last_grant_lsb_d = 1'b0;
            addr_d           = IFMC_addr;
            op_last_d        = 2'd3;
            cnt_d            = 3'd0;
            mem_a_d          = IFMC_addr;
            mem_wr_d         = 1'b0;
          end
        end
      end
      StIfRead, StLsbRead: begin
        if (RoB_clear) begin
          state_d = StIdle;
        end else begin
          // mem_din carries the byte addressed one cycle earlier.
          if (cnt_q != 3'd0) begin
            if (state_q == StIfRead) begin
              unique case (cap_idx)
                2'd0: word_d[7:0]   = mem_din;
                2'd1: word_d[15:8]  = mem_din;
                2'd2: word_d[23:16] = mem_din;
                2'd3: begin
                  mcif_en_d   = 1'b1;
                  mcif_data_d = {mem_din, word_q};
                end
              endcase
            end else begin
              mclsb_en_d   = 1'b1;
              mclsb_data_d = mem_din;
              mclsb_num_d  = cap_idx;
            end
          end
          if (cnt_q < {1'b0, op_last_q}) begin
            mem_a_d = next_addr;
          end
          if (cnt_q == last_p1) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StLsbWrite: begin
        // Committed stores ignore RoB_clear; an IO byte holds while the UART is full.
        if (!io_stall) begin
          if (cnt_q == {1'b0, op_last_q}) begin
            mem_wr_d  = 1'b0;
            wr_done_d = 1'b1;
            state_d   = StIdle;
          end else begin
            cnt_d      = cnt_inc;
            mem_a_d    = next_addr;
            mem_dout_d = lsb_data_q[{byte_sel, 3'b000} +: 8];
          end
        end
      end
    endcase

    if (RoB_clear) begin
      lsb_pending_d = 1'b0;
    end
  end

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      state_q          <= StIdle;
      cnt_q            <= 3'd0;
      addr_q           <= '0;
      op_last_q        <= 2'd0;
      last_grant_lsb_q <= 1'b0;
      lsb_pending_q    <= 1'b0;
      lsb_rd_q         <= 1'b0;
      lsb_last_q       <= 2'd0;
      lsb_data_q       <= 32'd0;
      lsb_addr_q       <= '0;
      word_q           <= 24'd0;
      mem_a_q          <= '0;
      mem_dout_q       <= 8'd0;
      mem_wr_q         <= 1'b0;
      mcif_en_q        <= 1'b0;
      mcif_data_q      <= 32'd0;
      mclsb_en_q       <= 1'b0;
      mclsb_data_q     <= 8'd0;
      mclsb_num_q      <= 2'd0;
      wr_done_q        <= 1'b0;
    end else if (Sys_rdy) begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      addr_q           <= addr_d;
      op_last_q        <= op_last_d;
      last_grant_lsb_q <= last_grant_lsb_d;
      lsb_pending_q    <= lsb_pending_d;
      lsb_rd_q         <= lsb_rd_d;
      lsb_last_q       <= lsb_last_d;
      lsb_data_q       <= lsb_data_d;
      lsb_addr_q       <= lsb_addr_d;
      word_q           <= word_d;
      mem_a_q          <= mem_a_d;
      mem_dout_q       <= mem_dout_d;
      mem_wr_q         <= mem_wr_d;
      mcif_en_q        <= mcif_en_d;
      mcif_data_q      <= mcif_data_d;
      mclsb_en_q       <= mclsb_en_d;
      mclsb_data_q     <= mclsb_data_d;
      mclsb_num_q      <= mclsb_num_d;
      wr_done_q        <= wr_done_d;
    end
  end

  assign mem_a             = mem_a_q;
  assign mem_dout          = mem_dout_q;
  assign mem_wr            = mem_wr_q && Sys_rdy && !io_stall;
  assign MCIF_en           = mcif_en_q;
  assign MCIF_data         = mcif_data_q;
  assign MCLSB_ready       = mclsb_ready;
  assign MCLSB_en          = mclsb_en_q;
  assign MCLSB_data        = mclsb_data_q;
  assign MCLSB_data_number = mclsb_num_q;
  assign MCLSB_wr_done     = wr_done_q;

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: byte-RAM model, event monitor, vector table and
// hand-timed sequences for arbitration, flush, IO stall, enable freeze and reset.
module tb_mem_controller;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst_n, Sys_rdy, RoB_clear, io_buffer_full;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        IFMC_en;
  logic [31:0] IFMC_addr;
  logic        MCIF_en;
  logic [31:0] MCIF_data;
  logic        LSBMC_en, LSBMC_wr;
  logic [1:0]  LSBMC_data_width;
  logic [31:0] LSBMC_data, LSBMC_addr;
  logic        MCLSB_ready, MCLSB_en, MCLSB_wr_done;
  logic [7:0]  MCLSB_data;
  logic [1:0]  MCLSB_data_number;

  mem_controller #(.ADDR_WIDTH(32), .IO_ADDR_HI(2'b11)) dut (
    .Sys_clk(Sys_clk), .Sys_rst_n(Sys_rst_n), .Sys_rdy(Sys_rdy), .RoB_clear(RoB_clear),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .IFMC_en(IFMC_en), .IFMC_addr(IFMC_addr),
    .MCIF_en(MCIF_en), .MCIF_data(MCIF_data), .LSBMC_en(LSBMC_en), .LSBMC_wr(LSBMC_wr),
    .LSBMC_data_width(LSBMC_data_width), .LSBMC_data(LSBMC_data), .LSBMC_addr(LSBMC_addr),
    .MCLSB_ready(MCLSB_ready), .MCLSB_en(MCLSB_en), .MCLSB_data(MCLSB_data),
    .MCLSB_data_number(MCLSB_data_number), .MCLSB_wr_done(MCLSB_wr_done)
  );

  always #5 Sys_clk = ~Sys_clk;

  int cyc = 0;
  always @(posedge Sys_clk) cyc <= cyc + 1;

  // RAM with one-cycle read latency, paused together with the rest of the system.
  logic [7:0] ram [4096];
  function automatic int ridx(input logic [31:0] a);
    return int'({a[17:16], a[9:0]});
  endfunction

  always @(posedge Sys_clk) begin
    if (!Sys_rst_n) begin
      mem_din    <= 8'd0;
      ram[12'h100] <= 8'h11; ram[12'h101] <= 8'h22; ram[12'h102] <= 8'h33; ram[12'h103] <= 8'h44;
      ram[12'h004] <= 8'h93; ram[12'h005] <= 8'h00; ram[12'h006] <= 8'hA0; ram[12'h007] <= 8'h00;
      ram[12'h008] <= 8'h13; ram[12'h009] <= 8'h05; ram[12'h00A] <= 8'h10; ram[12'h00B] <= 8'h00;
      ram[12'h010] <= 8'hEF; ram[12'h011] <= 8'hBE; ram[12'h012] <= 8'hAD; ram[12'h013] <= 8'hDE;
      ram[12'h000] <= 8'h5E; ram[12'hFFF] <= 8'h9C;
    end else if (Sys_rdy) begin
      mem_din <= ram[ridx(mem_a)];
      if (mem_wr) ram[ridx(mem_a)] <= mem_dout;
    end
  end

  int rd_num_q[$], rd_dat_q[$], rd_cyc_q[$], wr_adr_q[$];
  int done_cnt = 0;
  always @(negedge Sys_clk) begin
    if (Sys_rst_n) begin
      if (MCLSB_en) begin
        rd_num_q.push_back(int'(MCLSB_data_number));
        rd_dat_q.push_back(int'(MCLSB_data));
        rd_cyc_q.push_back(cyc);
      end
      if (mem_wr) wr_adr_q.push_back(int'(mem_a));
      if (MCLSB_wr_done) done_cnt++;
    end
  end

  int n_checks = 0, n_pass = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic lsb_pulse(input logic rd, input logic [1:0] w, input logic [31:0] a,
                           input logic [31:0] d);
    LSBMC_en = 1'b1; LSBMC_wr = rd; LSBMC_data_width = w; LSBMC_addr = a; LSBMC_data = d;
    tick();
    LSBMC_en = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic [1:0]  w;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          n;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int c, s_rd, s_wr, s_done, to;
    logic [31:0] got;

    vecs[0] = '{1'b1, 2'd0, 32'h0000_0100, 32'h0,         4, 32'h4433_2211};
    vecs[1] = '{1'b0, 2'd2, 32'h0000_0120, 32'h1234_BEEF, 2, 32'h0000_BEEF};
    vecs[2] = '{1'b1, 2'd2, 32'h0000_0120, 32'h0,         2, 32'h0000_BEEF};
    vecs[3] = '{1'b0, 2'd1, 32'h0000_0131, 32'hFFFF_FF5A, 1, 32'h0000_005A};
    vecs[4] = '{1'b1, 2'd1, 32'h0000_0131, 32'h0,         1, 32'h0000_005A};
    vecs[5] = '{1'b0, 2'd3, 32'h0000_0140, 32'hCAFE_F00D, 4, 32'hCAFE_F00D};
    vecs[6] = '{1'b1, 2'd0, 32'h0000_0140, 32'h0,         4, 32'hCAFE_F00D};
    vecs[7] = '{1'b1, 2'd1, 32'h0000_0102, 32'h0,         1, 32'h0000_0033};
    vecs[8] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0,         2, 32'h0000_5E9C};

    Sys_rst_n = 1'b0; Sys_rdy = 1'b1; RoB_clear = 1'b0; io_buffer_full = 1'b0;
    IFMC_en = 1'b0; IFMC_addr = 32'h0; LSBMC_en = 1'b0; LSBMC_wr = 1'b0;
    LSBMC_data_width = 2'd0; LSBMC_data = 32'h0; LSBMC_addr = 32'h0;
    repeat (3) @(posedge Sys_clk);
    #1;
    check("reset mem_a", mem_a, 32'h0);
    check("reset mem_wr", {31'b0, mem_wr}, 32'h0);
    check("reset mem_dout", {24'b0, mem_dout}, 32'h0);
    check("reset MCIF_en", {31'b0, MCIF_en}, 32'h0);
    check("reset MCIF_data", MCIF_data, 32'h0);
    check("reset MCLSB_en", {31'b0, MCLSB_en}, 32'h0);
    check("reset MCLSB_wr_done", {31'b0, MCLSB_wr_done}, 32'h0);
    check("reset MCLSB_ready", {31'b0, MCLSB_ready}, 32'h1);
    Sys_rst_n = 1'b1;

    // Tie after reset: LSB store wins, IF next, then an LSB load queued behind that fetch.
    tick();
    c = cyc;
    lsb_pulse(1'b0, 2'd1, 32'h200, 32'h0000_00AB);
    IFMC_en = 1'b1; IFMC_addr = 32'h4;
    tick();
    check("tie store mem_wr", {31'b0, mem_wr}, 32'h1);
    check("tie store mem_a", mem_a, 32'h200);
    check("tie store mem_dout", {24'b0, mem_dout}, 32'hAB);
    check("tie ready during write", {31'b0, MCLSB_ready}, 32'h0);
    tick();
    check("tie wr_done", {31'b0, MCLSB_wr_done}, 32'h1);
    check("tie wr after done", {31'b0, mem_wr}, 32'h0);
    tick();
    check("ready during fetch", {31'b0, MCLSB_ready}, 32'h1);
    s_rd = rd_num_q.size();
    lsb_pulse(1'b1, 2'd0, 32'h100, 32'h0);
    wait_cyc(c + 8);
    check("fetch1 not early", {31'b0, MCIF_en}, 32'h0);
    wait_cyc(c + 9);
    check("fetch1 MCIF_en", {31'b0, MCIF_en}, 32'h1);
    check("fetch1 data", MCIF_data, 32'h00A0_0093);
    IFMC_addr = 32'h8;
    wait_cyc(c + 16);
    check("queued load count", rd_num_q.size() - s_rd, 32'd4);
    if (rd_num_q.size() >= s_rd + 4) begin
      check("queued load first cycle", rd_cyc_q[s_rd], c + 12);
      got = {rd_dat_q[s_rd+3][7:0], rd_dat_q[s_rd+2][7:0], rd_dat_q[s_rd+1][7:0],
             rd_dat_q[s_rd][7:0]};
      check("queued load data", got, 32'h4433_2211);
    end
    wait_cyc(c + 20);
    check("fetch2 not early", {31'b0, MCIF_en}, 32'h0);
    wait_cyc(c + 21);
    check("fetch2 MCIF_en", {31'b0, MCIF_en}, 32'h1);
    check("fetch2 data", MCIF_data, 32'h0010_0513);
    IFMC_en = 1'b0;
    tick(); tick();

    for (int i = 0; i < 9; i++) begin
      for (int b = 0; b < 20 && !MCLSB_ready; b++) tick();
      s_rd = rd_num_q.size(); s_wr = wr_adr_q.size(); s_done = done_cnt;
      lsb_pulse(vecs[i].rd, vecs[i].w, vecs[i].addr, vecs[i].wdata);
      to = 1;
      for (int k = 0; k < 30; k++) begin
        if (vecs[i].rd ? (rd_num_q.size() >= s_rd + vecs[i].n) : (done_cnt > s_done)) begin
          to = 0;
          break;
        end
        tick();
      end
      check($sformatf("vec%0d timeout", i), to, 32'd0);
      got = 32'h0;
      if (vecs[i].rd) begin
        for (int j = 0; j < vecs[i].n; j++) begin
          if (s_rd + j < rd_num_q.size()) begin
            check($sformatf("vec%0d number %0d", i, j), rd_num_q[s_rd+j], j);
            got[8*j +: 8] = rd_dat_q[s_rd+j][7:0];
          end
        end
      end else begin
        check($sformatf("vec%0d write count", i), wr_adr_q.size() - s_wr, vecs[i].n);
        for (int j = 0; j < vecs[i].n; j++) got[8*j +: 8] = ram[ridx(vecs[i].addr + j)];
      end
      check($sformatf("vec%0d data", i), got, vecs[i].exp);
      tick();
      check($sformatf("vec%0d ready after", i), {31'b0, MCLSB_ready}, 32'h1);
    end

    // Flush during the second byte of a halfword load.
    s_rd = rd_num_q.size();
    lsb_pulse(1'b1, 2'd2, 32'h100, 32'h0);
    tick(); tick();
    RoB_clear = 1'b1;
    tick();
    RoB_clear = 1'b0;
    check("flush lh idle next", {31'b0, MCLSB_ready}, 32'h1);
    repeat (6) tick();
    check("flush lh no bytes", rd_num_q.size() - s_rd, 32'd0);

    // Flush during a word store is ignored.
    s_wr = wr_adr_q.size(); s_done = done_cnt;
    lsb_pulse(1'b0, 2'd0, 32'h180, 32'h0102_0304);
    tick(); tick();
    RoB_clear = 1'b1;
    tick();
    RoB_clear = 1'b0;
    for (int k = 0; k < 20 && done_cnt == s_done; k++) tick();
    tick(); tick();
    check("flush sw writes", wr_adr_q.size() - s_wr, 32'd4);
    check("flush sw done", done_cnt - s_done, 32'd1);
    check("flush sw data", {ram[ridx(32'h183)], ram[ridx(32'h182)], ram[ridx(32'h181)],
                            ram[ridx(32'h180)]}, 32'h0102_0304);

    // IO store held while the UART buffer is full.
    s_wr = wr_adr_q.size();
    io_buffer_full = 1'b1;
    lsb_pulse(1'b0, 2'd1, 32'h0003_0000, 32'h77);
    tick();
    check("io stall c0 mem_a", mem_a, 32'h0003_0000);
    check("io stall c0", {31'b0, mem_wr}, 32'h0);
    tick();
    check("io stall c1", {31'b0, mem_wr}, 32'h0);
    tick();
    check("io stall c2", {31'b0, mem_wr}, 32'h0);
    tick();
    io_buffer_full = 1'b0;
    #1;
    check("io release mem_wr", {31'b0, mem_wr}, 32'h1);
    check("io release dout", {24'b0, mem_dout}, 32'h77);
    tick();
    check("io wr_done", {31'b0, MCLSB_wr_done}, 32'h1);
    check("io single write", wr_adr_q.size() - s_wr, 32'd1);
    check("io ram byte", {24'b0, ram[ridx(32'h0003_0000)]}, 32'h77);

    // Global enable dropped for two cycles mid-fetch.
    tick();
    c = cyc;
    IFMC_en = 1'b1; IFMC_addr = 32'h10;
    wait_cyc(c + 3);
    check("rdy pre mem_a", mem_a, 32'h12);
    Sys_rdy = 1'b0;
    tick();
    check("rdy frozen mem_a", mem_a, 32'h12);
    tick();
    Sys_rdy = 1'b1;
    wait_cyc(c + 7);
    check("rdy fetch not early", {31'b0, MCIF_en}, 32'h0);
    wait_cyc(c + 8);
    check("rdy fetch MCIF_en", {31'b0, MCIF_en}, 32'h1);
    check("rdy fetch data", MCIF_data, 32'hDEAD_BEEF);
    IFMC_en = 1'b0;
    tick(); tick();

    // Asynchronous reset in the middle of a word store.
    lsb_pulse(1'b0, 2'd0, 32'h1C0, 32'hAABB_CCDD);
    tick();
    check("pre-reset mem_wr", {31'b0, mem_wr}, 32'h1);
    tick();
    Sys_rst_n = 1'b0;
    #1;
    check("async rst mem_wr", {31'b0, mem_wr}, 32'h0);
    check("async rst mem_a", mem_a, 32'h0);
    check("async rst mem_dout", {24'b0, mem_dout}, 32'h0);
    check("async rst ready", {31'b0, MCLSB_ready}, 32'h1);
    check("async rst MCIF_data", MCIF_data, 32'h0);
    tick();
    Sys_rst_n = 1'b1;
    tick(); tick();
    check("post-reset wr_done", {31'b0, MCLSB_wr_done}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
